// File: rtl/multi_debounce.sv
// Multi-channel switch debouncer: shared tick prescaler, 2-flop synchronisers, DEPTH-sample hysteresis.
// Optional auto-repeat of press pulses while held, enabled by defining MULTI_DEBOUNCE_REPEAT_EN.
module multi_debounce #(
  parameter int N         = 4,
  parameter int DEPTH     = 3,
  parameter int TICK_W    = 21,
  parameter int EXCL      = 1,
  parameter int REP_DELAY = 16,
  parameter int REP_RATE  = 4
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic [N-1:0] x_in,
  output logic [N-1:0] x_level,
  output logic [N-1:0] x_press,
  output logic [N-1:0] x_release
);

  if (N < 1 || N > 32 || DEPTH < 2 || DEPTH > 8 || TICK_W < 1) begin : g_bad_cfg
    $error("multi_debounce: N, DEPTH or TICK_W out of range");
  end
  if (REP_RATE < 1 || REP_RATE > REP_DELAY) begin : g_bad_rep_cfg
    $error("multi_debounce: REP_RATE must be in 1..REP_DELAY");
  end

  logic [TICK_W-1:0]         r_presc;
  logic [N-1:0]              r_sync1;
  logic [N-1:0]              r_sync2;
  logic [N-1:0][DEPTH-1:0]   r_shift;
  logic [N-1:0]              r_level;
  logic [N-1:0]              r_press;
  logic [N-1:0]              r_release;
  logic                      w_tick;
  logic [N-1:0]              w_qual;
  logic [N-1:0]              w_all1;
  logic [N-1:0]              w_all0;
  logic [N-1:0]              w_press_next;

  assign w_tick = &r_presc;

  // Exclusive mode: a channel only counts as pressed when it is the sole high input.
  always_comb begin
    w_qual = r_sync2;
    if (EXCL != 0 && N > 1 && !$onehot0(r_sync2)) w_qual = '0;
  end

  always_comb begin
    w_all1 = '0;
    w_all0 = '0;
    for (int i = 0; i < N; i++) begin
      w_all1[i] = &r_shift[i];
      w_all0[i] = ~|r_shift[i];
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_shift   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_presc   <= r_presc + TICK_W'(1);
      r_sync1   <= x_in;
      r_sync2   <= r_sync1;
      if (w_tick) begin
        for (int i = 0; i < N; i++) r_shift[i] <= {r_shift[i][DEPTH-2:0], w_qual[i]};
      end
      for (int i = 0; i < N; i++) begin
        if (w_all1[i])      r_level[i] <= 1'b1;
        else if (w_all0[i]) r_level[i] <= 1'b0;
      end
      r_press   <= w_press_next;
      r_release <= w_all0 & r_level;
    end
  end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int REP_W = $clog2(REP_DELAY + 1);

  logic                    r_tick_d;
  logic [N-1:0][REP_W-1:0] r_rep_cnt;
  logic [N-1:0]            w_rep;

  // Counting happens on the cycle after the tick so repeats line up with the initial press.
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < N; i++) begin
      if (r_tick_d && r_level[i] && !w_all0[i] && r_rep_cnt[i] == REP_W'(REP_DELAY - 1))
        w_rep[i] = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_tick_d  <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_tick_d <= w_tick;
      for (int i = 0; i < N; i++) begin
        if (!r_level[i] || w_all0[i]) r_rep_cnt[i] <= '0;
        else if (r_tick_d)             r_rep_cnt[i] <= w_rep[i] ? REP_W'(REP_DELAY - REP_RATE)
                                                                 : r_rep_cnt[i] + REP_W'(1);
      end
    end
  end

  assign w_press_next = (w_all1 & ~r_level) | w_rep;
`else
  assign w_press_next = w_all1 & ~r_level;
`endif

  assign x_level   = r_level;
  assign x_press   = r_press;
  assign x_release = r_release;

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: two instances (exclusive and independent) checked every cycle against
// a sample-history reference model, plus directed timing sequences and a steady-state vector table.
module tb_multi_debounce;
  localparam int N           = 4;
  localparam int DEPTH       = 3;
  localparam int TICK_W      = 4;
  localparam int REP_DELAY   = 16;
  localparam int REP_RATE    = 4;
  localparam int TICK_PERIOD = 1 << TICK_W;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
  localparam int EXP_HOLD_PRESSES = 7;
`else
  localparam int EXP_HOLD_PRESSES = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] x_a = '0;
  logic [N-1:0] x_b = '0;
  logic [N-1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
  int           errors = 0;
  int           checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  multi_debounce #(.N(N), .DEPTH(DEPTH), .TICK_W(TICK_W), .EXCL(1),
                   .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_excl (
    .sysclk(clk), .reset(rst), .x_in(x_a),
    .x_level(lvl_a), .x_press(prs_a), .x_release(rel_a));

  multi_debounce #(.N(N), .DEPTH(DEPTH), .TICK_W(TICK_W), .EXCL(0),
                   .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_indep (
    .sysclk(clk), .reset(rst), .x_in(x_b),
    .x_level(lvl_b), .x_press(prs_b), .x_release(rel_b));

  // reference model: index 0 = exclusive instance, 1 = independent instance
  logic [N-1:0] dly_q [2][$];
  logic         smp_q [2][N][$];
  logic [N-1:0] m_level [2];
  logic [N-1:0] m_press [2];
  logic [N-1:0] m_release [2];
  int           hold [2][N];
  int           cyc;
  bit           prev_tick;

  // event trackers for directed sequences
  int           ph, npa, pca, nra, rca, npb, pcb, nrb, nz;
  logic [N-1:0] pva, rva, pvb, rvb;

  typedef struct {
    logic [N-1:0] xa;
    logic [N-1:0] xb;
    logic [N-1:0] la;
    logic [N-1:0] lb;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    prev_tick = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dly_q[d] = {};
      dly_q[d].push_back('0);
      dly_q[d].push_back('0);
      m_level[d] = '0;
      m_press[d] = '0;
      m_release[d] = '0;
      for (int ch = 0; ch < N; ch++) begin
        smp_q[d][ch] = {};
        for (int k = 0; k < DEPTH; k++) smp_q[d][ch].push_back(1'b0);
        hold[d][ch] = 0;
      end
    end
  endtask

  task automatic model_step(input logic [N-1:0] xa, input logic [N-1:0] xb);
    logic [N-1:0] x, sync, q;
    logic         all1, all0, old_l, new_l, p, r;
    bit           tick;
    tick = (cyc % TICK_PERIOD) == (TICK_PERIOD - 1);
    for (int d = 0; d < 2; d++) begin
      x = (d == 0) ? xa : xb;
      sync = dly_q[d].pop_front();
      dly_q[d].push_back(x);
      q = sync;
      if (d == 0 && $countones(sync) != 1) q = '0;
      for (int ch = 0; ch < N; ch++) begin
        all1 = 1'b1;
        all0 = 1'b1;
        for (int k = 0; k < smp_q[d][ch].size(); k++) begin
          if (smp_q[d][ch][k]) all0 = 1'b0;
          else                 all1 = 1'b0;
        end
        old_l = m_level[d][ch];
        new_l = all1 ? 1'b1 : (all0 ? 1'b0 : old_l);
        p = new_l & ~old_l;
        r = old_l & ~new_l;
`ifdef MULTI_DEBOUNCE_REPEAT_EN
        if (!new_l || p) hold[d][ch] = 0;
        else if (prev_tick) begin
          hold[d][ch]++;
          if (hold[d][ch] >= REP_DELAY && (hold[d][ch] - REP_DELAY) % REP_RATE == 0) p = 1'b1;
        end
`endif
        m_level[d][ch]   = new_l;
        m_press[d][ch]   = p;
        m_release[d][ch] = r;
        if (tick) begin
          smp_q[d][ch].push_back(q[ch]);
          void'(smp_q[d][ch].pop_front());
        end
      end
    end
    prev_tick = tick;
    cyc++;
  endtask

  task automatic trk_clear();
    ph = 0; npa = 0; pca = -1; nra = 0; rca = -1; npb = 0; pcb = -1; nrb = 0; nz = 0;
    pva = '0; rva = '0; pvb = '0; rvb = '0;
  endtask

  // driver: one clock cycle, inputs applied at the falling edge, outputs sampled 1 after rising edge
  task automatic step(input logic [N-1:0] xa, input logic [N-1:0] xb);
    x_a = xa;
    x_b = xb;
    @(posedge clk);
    model_step(xa, xb);
    #1;
    chk("outs_excl", {lvl_a, prs_a, rel_a}, {m_level[0], m_press[0], m_release[0]});
    chk("outs_indep", {lvl_b, prs_b, rel_b}, {m_level[1], m_press[1], m_release[1]});
    ph++;
    if (prs_a != '0) begin npa++; pca = ph; pva |= prs_a; end
    if (rel_a != '0) begin nra++; rca = ph; rva |= rel_a; end
    if (prs_b != '0) begin npb++; pcb = ph; pvb |= prs_b; end
    if (rel_b != '0) begin nrb++; rvb |= rel_b; end
    if ({lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b} != '0) nz++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] xa, input logic [N-1:0] xb);
    x_a = xa;
    x_b = xb;
    rst = 1'b1;
    #1;
    chk("rst_clear_excl", {lvl_a, prs_a, rel_a}, 0);
    chk("rst_clear_indep", {lvl_b, prs_b, rel_b}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int           len;

    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    tbl[1] = '{4'b0011, 4'b0011, 4'b0000, 4'b0011};
    tbl[2] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110};
    tbl[3] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    tbl[4] = '{4'b1000, 4'b1001, 4'b1000, 4'b1001};
    tbl[5] = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    trk_clear();
    model_reset();

    repeat (2) @(negedge clk);
    chk("reset_state_excl", {lvl_a, prs_a, rel_a}, 0);
    chk("reset_state_indep", {lvl_b, prs_b, rel_b}, 0);

    // single channel held from reset release: press one cycle after the third tick
    do_reset(4'b0001, 4'b0000);
    trk_clear();
    repeat (80) step(4'b0001, 4'b0000);
    chk("single_press_count", npa, 1);
    chk("single_press_cycle", pca, 49);
    chk("single_press_value", pva, 4'b0001);
    chk("single_no_release", nra, 0);
    chk("single_level", lvl_a, 4'b0001);

    // reset while the press pulse is high, then the press must come back with the same latency
    do_reset(4'b0001, 4'b0000);
    repeat (49) step(4'b0001, 4'b0000);
    chk("pulse_before_reset", prs_a, 4'b0001);
    do_reset(4'b0001, 4'b0000);
    trk_clear();
    repeat (80) step(4'b0001, 4'b0000);
    chk("rerun_press_cycle", pca, 49);
    chk("rerun_press_count", npa, 1);
    chk("rerun_no_release", nra, 0);

    // two-tick glitch on channel 2 must leave every output quiet
    do_reset(4'b0000, 4'b0000);
    trk_clear();
    repeat (32) step(4'b0100, 4'b0100);
    repeat (64) step(4'b0000, 4'b0000);
    chk("glitch_quiet", nz, 0);

    // joint press on the independent instance; contention on the exclusive one
    do_reset(4'b0001, 4'b0101);
    trk_clear();
    repeat (64) step(4'b0001, 4'b0101);
    chk("pair_press_value", pvb, 4'b0101);
    chk("pair_press_count", npb, 1);
    chk("pair_press_cycle", pcb, 49);
    trk_clear();
    repeat (80) step(4'b0011, 4'b0000);
    chk("excl_release_cycle", rca, 49);
    chk("excl_release_value", rva, 4'b0001);
    chk("excl_no_press", npa, 0);
    chk("excl_level", lvl_a, 4'b0000);
    chk("pair_release_value", rvb, 4'b0101);
    chk("pair_release_count", nrb, 1);

    // long hold: hold ticks 0..39 after the press tick
    do_reset(4'b1000, 4'b1000);
    trk_clear();
    repeat (49 + 16 * 39) step(4'b1000, 4'b1000);
    chk("hold_presses_excl", npa, EXP_HOLD_PRESSES);
    chk("hold_presses_indep", npb, EXP_HOLD_PRESSES);
    chk("hold_no_release", nra + nrb, 0);

    // steady-state vector table: each entry held for four ticks
    do_reset(4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      repeat (4 * TICK_PERIOD) step(tbl[i].xa, tbl[i].xb);
      chk($sformatf("table_%0d_level_excl", i), lvl_a, tbl[i].la);
      chk($sformatf("table_%0d_level_indep", i), lvl_b, tbl[i].lb);
    end

    // randomized bursts of varying length against the model
    do_reset(4'b0000, 4'b0000);
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 80);
      repeat (len) step(ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
